// File: rtl/uart_rx_deframe_if.sv
// Frame and host-side handshake bundle for the UART receive deframer.
// The receiver drives frame_in/frame_valid and the host drives data_ready.
interface uart_rx_deframe_if;
  logic [10:0] frame_in;
  logic        frame_valid;
  logic [7:0]  data_out;
  logic        parity_err;
  logic        framing_err;
  logic        data_valid;
  logic        data_ready;

  modport master (
    output frame_in, frame_valid, data_ready,
    input  data_out, parity_err, framing_err, data_valid
  );

  modport slave (
    input  frame_in, frame_valid, data_ready,
    output data_out, parity_err, framing_err, data_valid
  );
endinterface

// File: rtl/uart_rx_deframe.sv
// UART receive deframer: checks start/stop/parity on each captured frame and queues
// the byte with its error tags in a show-ahead FIFO; sticky overrun on dropped frames.
module uart_rx_deframe #(
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          baud_clk,
  input  logic                          rst_n,
  uart_rx_deframe_if.slave              bus,
  input  logic                          i_err_clr,
  output logic                          o_overrun_err,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Stored entry layout: {framing_err, parity_err, data[7:0]}
  localparam int EW = 10;

  function automatic logic f_parity_err(input logic [8:0] bits);
    logic want;
    want = (PARITY_ODD != 0);
    return (PARITY_EN != 0) && ((^bits) != want);
  endfunction

  function automatic logic f_framing_err(input logic start_b, input logic stop_b);
    return start_b | ~stop_b;
  endfunction

  logic                r_frame_valid_p0;
  logic                w_vld_p0;
  logic [EW-1:0]       w_entry_p0;

  logic [EW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_overrun;

  logic                w_not_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push_ok;
  logic                w_drop;
  logic [EW-1:0]       w_head;

  // Stage p0: rising-edge capture of the receiver flag and frame checks.
  // The delayed flag resets high so a flag already asserted at reset release is ignored.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) r_frame_valid_p0 <= 1'b1;
    else        r_frame_valid_p0 <= bus.frame_valid;
  end

  assign w_vld_p0   = bus.frame_valid & ~r_frame_valid_p0;
  assign w_entry_p0 = {f_framing_err(bus.frame_in[0], bus.frame_in[10]),
                       f_parity_err(bus.frame_in[9:1]),
                       bus.frame_in[8:1]};

  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = w_not_empty & bus.data_ready;
  // A full FIFO still takes the frame when the head leaves on the same edge.
  assign w_push_ok   = w_vld_p0 & (~w_full | w_pop);
  assign w_drop      = w_vld_p0 & w_full & ~w_pop;

  // Stage p1: FIFO storage; data array carries no reset.
  always_ff @(posedge baud_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_entry_p0;
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop coinciding with a clear keeps the flag set.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n)         r_overrun <= 1'b0;
    else if (w_drop)    r_overrun <= 1'b1;
    else if (i_err_clr) r_overrun <= 1'b0;
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign bus.data_valid  = w_not_empty;
  assign bus.data_out    = w_not_empty ? w_head[7:0] : 8'h00;
  assign bus.parity_err  = w_not_empty & w_head[8];
  assign bus.framing_err = w_not_empty & w_head[9];
  assign o_overrun_err   = r_overrun;
  assign o_fifo_count    = r_count;

endmodule

// File: tb/tb_uart_rx_deframe.sv
// Scoreboard bench for uart_rx_deframe: expected entries are queued as frames are
// issued and a negedge monitor compares the FIFO head on every accepted pop.
module tb_uart_rx_deframe;
  logic       baud_clk = 1'b0;
  logic       rst_n;
  logic       err_clr;
  logic       ovr, ovr2;
  logic [2:0] cnt, cnt2;

  int n_total = 0;
  int n_pass  = 0;

  logic [9:0] exp_q [$];
  logic [9:0] exp_e;

  uart_rx_deframe_if u_if ();
  uart_rx_deframe_if u_if2 ();

  assign u_if2.frame_in    = u_if.frame_in;
  assign u_if2.frame_valid = u_if.frame_valid;
  assign u_if2.data_ready  = u_if.data_ready;

  uart_rx_deframe #(.PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut (
    .baud_clk(baud_clk), .rst_n(rst_n), .bus(u_if.slave),
    .i_err_clr(err_clr), .o_overrun_err(ovr), .o_fifo_count(cnt)
  );

  uart_rx_deframe #(.PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut_np (
    .baud_clk(baud_clk), .rst_n(rst_n), .bus(u_if2.slave),
    .i_err_clr(err_clr), .o_overrun_err(ovr2), .o_fifo_count(cnt2)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid && ready here.
  always @(negedge baud_clk) begin
    if (rst_n === 1'b1 && u_if.data_valid === 1'b1 && u_if.data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {22'd0, u_if.framing_err, u_if.parity_err, u_if.data_out}, 32'h0);
        chk("unexpected_pop_queue", 32'd0, 32'd1);
      end else begin
        exp_e = exp_q.pop_front();
        chk("pop_data",    {24'd0, u_if.data_out}, {24'd0, exp_e[7:0]});
        chk("pop_parity",  {31'd0, u_if.parity_err}, {31'd0, exp_e[8]});
        chk("pop_framing", {31'd0, u_if.framing_err}, {31'd0, exp_e[9]});
        chk("np_data",     {24'd0, u_if2.data_out}, {24'd0, exp_e[7:0]});
        chk("np_parity",   {31'd0, u_if2.parity_err}, 32'd0);
      end
    end
  end

  // Called just after a rising edge; the frame is pushed on the next edge.
  task automatic send(input logic [10:0] f, input int hold);
    u_if.frame_in    = f;
    u_if.frame_valid = 1'b1;
    repeat (hold) @(posedge baud_clk);
    #1 u_if.frame_valid = 1'b0;
    @(posedge baud_clk); #1;
  endtask

  task automatic expect_entry(input logic [7:0] d, input logic par, input logic frm);
    exp_q.push_back({frm, par, d});
  endtask

  task automatic drain(input int n);
    u_if.data_ready = 1'b1;
    repeat (n) @(posedge baud_clk);
    #1 u_if.data_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got 0, required 1");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    err_clr          = 1'b0;
    u_if.frame_in    = 11'h000;
    u_if.frame_valid = 1'b1;
    u_if.data_ready  = 1'b0;
    #3;
    chk("rst_valid", {31'd0, u_if.data_valid}, 32'd0);
    chk("rst_data",  {24'd0, u_if.data_out}, 32'd0);
    chk("rst_count", {29'd0, cnt}, 32'd0);
    chk("rst_ovr",   {31'd0, ovr}, 32'd0);
    repeat (2) @(posedge baud_clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge baud_clk);
    #1 chk("flag_high_at_release", {29'd0, cnt}, 32'd0);
    u_if.frame_valid = 1'b0;
    @(posedge baud_clk); #1;

    // Clean frame 0xA5, then visible one edge later.
    send(11'h54A, 1); expect_entry(8'hA5, 1'b0, 1'b0);
    chk("t1_valid",   {31'd0, u_if.data_valid}, 32'd1);
    chk("t1_data",    {24'd0, u_if.data_out}, 32'h A5);
    chk("t1_parity",  {31'd0, u_if.parity_err}, 32'd0);
    chk("t1_framing", {31'd0, u_if.framing_err}, 32'd0);
    chk("t1_count",   {29'd0, cnt}, 32'd1);

    send(11'h74A, 1); expect_entry(8'hA5, 1'b1, 1'b0);
    send(11'h14A, 1); expect_entry(8'hA5, 1'b0, 1'b1);
    send(11'h54B, 1); expect_entry(8'hA5, 1'b0, 1'b1);
    chk("t2_count", {29'd0, cnt}, 32'd4);
    drain(4);
    chk("drain_count", {29'd0, cnt}, 32'd0);
    chk("empty_valid", {31'd0, u_if.data_valid}, 32'd0);
    chk("empty_data",  {24'd0, u_if.data_out}, 32'd0);
    drain(2);
    chk("ready_when_empty", {29'd0, cnt}, 32'd0);

    // Long-held flag: one capture per rising transition.
    send(11'h54A, 2); expect_entry(8'hA5, 1'b0, 1'b0);
    chk("hold2_count", {29'd0, cnt}, 32'd1);
    send(11'h478, 5); expect_entry(8'h3C, 1'b0, 1'b0);
    chk("hold5_count", {29'd0, cnt}, 32'd2);
    drain(2);

    // Overrun: five frames into a four-deep FIFO.
    send(11'h602, 1); expect_entry(8'h01, 1'b0, 1'b0);
    send(11'h604, 1); expect_entry(8'h02, 1'b0, 1'b0);
    send(11'h406, 1); expect_entry(8'h03, 1'b0, 1'b0);
    send(11'h608, 1); expect_entry(8'h04, 1'b0, 1'b0);
    chk("pre_ovr", {31'd0, ovr}, 32'd0);
    send(11'h40A, 1);
    chk("ovr_count", {29'd0, cnt}, 32'd4);
    chk("ovr_set",   {31'd0, ovr}, 32'd1);
    chk("ovr_head",  {24'd0, u_if.data_out}, 32'h01);

    // Drop together with clear: set wins.
    u_if.frame_in = 11'h40A; u_if.frame_valid = 1'b1; err_clr = 1'b1;
    @(posedge baud_clk); #1;
    u_if.frame_valid = 1'b0; err_clr = 1'b0;
    chk("ovr_set_wins", {31'd0, ovr}, 32'd1);
    err_clr = 1'b1;
    @(posedge baud_clk); #1 err_clr = 1'b0;
    chk("ovr_cleared", {31'd0, ovr}, 32'd0);

    // Full FIFO: push and pop on the same edge.
    u_if.frame_in = 11'h40C; u_if.frame_valid = 1'b1; u_if.data_ready = 1'b1;
    expect_entry(8'h06, 1'b0, 1'b0);
    @(posedge baud_clk); #1;
    u_if.frame_valid = 1'b0; u_if.data_ready = 1'b0;
    chk("full_pushpop_count", {29'd0, cnt}, 32'd4);
    chk("full_pushpop_ovr",   {31'd0, ovr}, 32'd0);
    drain(4);
    chk("after_wrap_count", {29'd0, cnt}, 32'd0);

    // Reset mid-stream flushes immediately.
    send(11'h602, 1); send(11'h604, 1); send(11'h406, 1);
    send(11'h608, 1); send(11'h40A, 1);
    chk("pre_rst_ovr", {31'd0, ovr}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", {31'd0, u_if.data_valid}, 32'd0);
    chk("midrst_count", {29'd0, cnt}, 32'd0);
    chk("midrst_ovr",   {31'd0, ovr}, 32'd0);
    @(posedge baud_clk); #1 rst_n = 1'b1;
    @(posedge baud_clk); #1;
    send(11'h478, 1); expect_entry(8'h3C, 1'b0, 1'b0);
    chk("post_rst_count", {29'd0, cnt}, 32'd1);
    drain(1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
